// File: rtl/ahfp_cordic_prep.sv
// ahfp_cordic_prep: front end of the ahfp_cordic pipeline.
// Takes an IEEE-754 single angle in radians, reduces it into [-pi/2, +pi/2]
// and emits (x_start, y_start, theta_out). The start vector absorbs the
// quadrant fold, so the downstream CORDIC directly produces cos/sin of the input.
// One combinational FP adder is shared, so reduction takes one cycle per
// 2*pi step.
// Optional feature macro: AHFP_CORDIC_PREP_ERR_EN enables the err output
// (non-finite input detection and iteration-cap overflow).
`timescale 1ns/1ps
module ahfp_cordic_prep #(
  parameter int          MAX_ITER = 8,
  parameter logic [31:0] K_CONST  = 32'h3F1B74EE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] theta_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] x_start,
  output logic [31:0] y_start,
  output logic [31:0] theta_out,
  output logic        err,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high. in_ready is high exactly while idle; out_valid, once high,
  // holds with all output data stable until the edge where out_ready is high.

`ifdef AHFP_CORDIC_PREP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam logic [30:0] PI_MAG      = 31'h40490FDB;
  localparam logic [30:0] HALF_PI_MAG = 31'h3FC90FDB;
  localparam logic [30:0] TWO_PI_MAG  = 31'h40C90FDB;
  localparam int          IW          = $clog2(MAX_ITER + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_FOLD   = 2'd2,
    S_OUT    = 2'd3
  } state_t;

  state_t        state_q;
  logic [31:0]   z_q;
  logic [IW-1:0] iter_q;
  logic          err_flag_q;
  logic [31:0]   x_q;
  logic [31:0]   theta_q;
  logic          out_valid_q;
  logic          err_q;

  // Shared adder operands: datab always has the sign opposite to z, which
  // pulls z toward zero by 2*pi while reducing and by pi while folding.
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] sum_d;

  assign add_a = z_q;
  assign add_b = {~z_q[31], (state_q == S_FOLD) ? PI_MAG : TWO_PI_MAG};

  // Adder internals (round-to-nearest-even, denormals flushed to zero)
  logic        swap;
  logic [31:0] op_x;
  logic [31:0] op_y;
  logic [7:0]  ex;
  logic [7:0]  ey;
  logic [7:0]  ediff;
  logic [23:0] mx;
  logic [23:0] my;
  logic [27:0] fa;
  logic [27:0] fb_raw;
  logic [27:0] fb;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [26:0] norm;
  logic [9:0]  e10;
  logic        round_up;
  logic [24:0] m25;
  logic [22:0] frac;

  // Combinational single-precision add: align, add/sub, normalise, round.
  always_comb begin
    swap     = (add_b[30:0] > add_a[30:0]);
    op_x     = swap ? add_b : add_a;
    op_y     = swap ? add_a : add_b;
    ex       = op_x[30:23];
    ey       = op_y[30:23];
    ediff    = ex - ey;
    mx       = (ex != 8'd0) ? {1'b1, op_x[22:0]} : 24'd0;
    my       = (ey != 8'd0) ? {1'b1, op_y[22:0]} : 24'd0;
    fa       = {1'b0, mx, 3'b000};
    fb_raw   = {1'b0, my, 3'b000};
    fb       = 28'd0;
    sum      = 28'd0;
    lz       = 5'd0;
    norm     = 27'd0;
    e10      = 10'd0;
    round_up = 1'b0;
    m25      = 25'd0;
    frac     = 23'd0;
    sum_d    = 32'd0;

    // Align the smaller operand; everything shifted out collapses into a sticky LSB.
    if (ediff >= 8'd27) begin
      fb = {27'd0, |my};
    end else begin
      fb    = fb_raw >> ediff;
      fb[0] = fb[0] | (|(fb_raw & ((28'd1 << ediff) - 28'd1)));
    end

    sum = (op_x[31] == op_y[31]) ? (fa + fb) : (fa - fb);

    for (int i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end

    if (sum[27]) begin
      norm = {sum[27:2], sum[1] | sum[0]};
      e10  = {2'b00, ex} + 10'd1;
    end else begin
      norm = sum[26:0] << lz;
      e10  = {2'b00, ex} - {5'd0, lz};
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    m25      = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (m25[24]) begin
      e10  = e10 + 10'd1;
      frac = m25[23:1];
    end else begin
      frac = m25[22:0];
    end

    if (ex == 8'd0) begin
      sum_d = {op_x[31] & op_y[31], 31'd0};
    end else if (sum == 28'd0) begin
      sum_d = 32'd0;
    end else if (e10[9] || (e10 == 10'd0)) begin
      sum_d = {op_x[31], 31'd0};
    end else if (e10 >= 10'd255) begin
      sum_d = {op_x[31], 8'hFF, 23'd0};
    end else begin
      sum_d = {op_x[31], e10[7:0], frac};
    end
  end

  logic z_gt_pi;
  logic z_gt_half_pi;
  assign z_gt_pi      = (z_q[30:0] > PI_MAG);
  assign z_gt_half_pi = (z_q[30:0] > HALF_PI_MAG);

  // Control FSM with registered outputs: capture, reduce, fold, present.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      z_q         <= 32'd0;
      iter_q      <= '0;
      err_flag_q  <= 1'b0;
      x_q         <= 32'd0;
      theta_q     <= 32'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            iter_q     <= '0;
            err_flag_q <= 1'b0;
            if (ErrEn && (theta_in[30:23] == 8'hFF)) begin
              // Inf/NaN cannot be reduced: present a zero angle flagged as invalid.
              z_q        <= 32'd0;
              err_flag_q <= 1'b1;
              state_q    <= S_FOLD;
            end else begin
              z_q     <= theta_in;
              state_q <= S_REDUCE;
            end
          end
        end
        S_REDUCE: begin
          if (z_gt_pi) begin
            if (iter_q == IW'(MAX_ITER)) begin
              err_flag_q <= 1'b1;
              state_q    <= S_FOLD;
            end else begin
              z_q    <= sum_d;
              iter_q <= iter_q + IW'(1);
            end
          end else begin
            state_q <= S_FOLD;
          end
        end
        S_FOLD: begin
          // Outside +-pi/2 the angle is shifted by pi and the start vector negated.
          if (z_gt_half_pi) begin
            theta_q <= sum_d;
            x_q     <= {~K_CONST[31], K_CONST[30:0]};
          end else begin
            theta_q <= z_q;
            x_q     <= K_CONST;
          end
          err_q   <= ErrEn & err_flag_q;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = out_valid_q;
  assign x_start     = x_q;
  assign y_start     = 32'd0;
  assign theta_out   = theta_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ahfp_cordic_prep.sv
// Bench for ahfp_cordic_prep: directed angles, a real-arithmetic reference
// model with a scoreboard, latency/handshake checks and a mid-run reset.
`timescale 1ns/1ps
module tb_ahfp_cordic_prep;

  localparam int          MAX_ITER = 8;
  localparam logic [31:0] K_POS    = 32'h3F1B74EE;
  localparam logic [31:0] K_NEG    = 32'hBF1B74EE;
  localparam logic [31:0] PI       = 32'h40490FDB;
  localparam logic [31:0] NEG_PI   = 32'hC0490FDB;
  localparam logic [31:0] HALF_PI  = 32'h3FC90FDB;
  localparam logic [31:0] TWO_PI   = 32'h40C90FDB;
  localparam logic [31:0] NEG_2PI  = 32'hC0C90FDB;

`ifdef AHFP_CORDIC_PREP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] theta_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] x_start;
  logic [31:0] y_start;
  logic [31:0] theta_out;
  logic        err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] exp_theta_q[$];
  logic [31:0] exp_x_q[$];
  logic        exp_err_q[$];
  bit          exp_data_q[$];

  ahfp_cordic_prep #(.MAX_ITER(MAX_ITER), .K_CONST(K_POS)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .theta_in   (theta_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .x_start    (x_start),
    .y_start    (y_start),
    .theta_out  (theta_out),
    .err        (err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- check helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- reference model (real arithmetic) ----------------
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  // Round a double to the nearest single (ties to even); normal range only.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [52:0] m;
    logic [24:0] m24;
    logic [28:0] rem;
    int          e;
    if (r == 0.0) return 32'd0;
    d   = $realtobits(r);
    e   = int'(d[62:52]) - 1023 + 127;
    m   = {1'b1, d[51:0]};
    m24 = {1'b0, m[52:29]};
    rem = m[28:0];
    if ((rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && m24[0])) m24 = m24 + 25'd1;
    if (m24[24]) begin
      e   = e + 1;
      m24 = m24 >> 1;
    end
    return {d[63], 8'(e), m24[22:0]};
  endfunction

  // Exact double sum of two singles, rounded once to single.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic model(input logic [31:0] th, output logic [31:0] e_theta, output logic [31:0] e_x,
                       output logic e_err, output int e_lat, output bit e_data);
    logic [31:0] z;
    real         zr;
    int          k;
    bit          ovf;
    k   = 0;
    ovf = 1'b0;
    e_data = 1'b1;
    if (th[30:23] == 8'hFF) begin
      if (ERR_EN) begin
        e_theta = 32'd0; e_x = K_POS; e_err = 1'b1; e_lat = 2;
      end else begin
        e_data = 1'b0; e_theta = 32'd0; e_x = 32'd0; e_err = 1'b0; e_lat = 3 + MAX_ITER;
      end
    end else begin
      z  = th;
      zr = f2r(z);
      while (((zr < 0.0) ? -zr : zr) > f2r(PI)) begin
        if (k == MAX_ITER) begin
          ovf = 1'b1;
          break;
        end
        z  = fadd(z, (zr < 0.0) ? TWO_PI : NEG_2PI);
        zr = f2r(z);
        k++;
      end
      if (zr > f2r(HALF_PI)) begin
        e_theta = fadd(z, NEG_PI); e_x = K_NEG;
      end else if (zr < -f2r(HALF_PI)) begin
        e_theta = fadd(z, PI); e_x = K_NEG;
      end else begin
        e_theta = z; e_x = K_POS;
      end
      e_err = ERR_EN && ovf;
      e_lat = 3 + k;
    end
  endtask

  // ---------------- scoreboard compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        if (exp_theta_q.size() == 0) begin
          check("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (exp_data_q[0]) begin
            check("theta_out", theta_out, exp_theta_q[0]);
            check("x_start", x_start, exp_x_q[0]);
            check("err", {31'd0, err}, {31'd0, exp_err_q[0]});
          end
          check("y_start", y_start, 32'd0);
          check("in_ready_while_out", {31'd0, in_ready}, 32'd0);
          if (out_ready) begin
            exp_theta_q.delete(0);
            exp_x_q.delete(0);
            exp_err_q.delete(0);
            exp_data_q.delete(0);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] th, input int hold, input bit pulse_busy);
    logic [31:0] e_theta;
    logic [31:0] e_x;
    logic        e_err;
    int          e_lat;
    bit          e_data;
    int          acc;
    bit          ok;
    model(th, e_theta, e_x, e_err, e_lat, e_data);
    exp_theta_q.push_back(e_theta);
    exp_x_q.push_back(e_x);
    exp_err_q.push_back(e_err);
    exp_data_q.push_back(e_data);

    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("in_ready_wait");
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    theta_in  = th;
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
    theta_in = 32'hDEADBEEF;
    if (pulse_busy) begin
      in_valid = 1'b1;
      theta_in = 32'h3F800000;
      @(posedge clk);
      @(posedge clk);
      #1 in_valid = 1'b0;
    end

    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("out_valid_wait");
    else check("latency", 32'(cyc - acc), 32'(e_lat));

    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 out_ready = 1'b1;
    end

    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("out_handshake_wait");
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] vecs[12] = '{
    32'h3F000000, 32'h40000000, 32'hC0000000, 32'h40E00000,
    32'h40490FDB, 32'hC0490FDB, 32'h3FC90FDB, 32'hBFC90FDB,
    32'h80000000, 32'h41200000, 32'hC1A00000, 32'h42C80000
  };

  initial begin
    logic [31:0] e_theta;
    logic [31:0] e_x;
    logic        e_err;
    int          e_lat;
    bit          e_data;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    theta_in  = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_x_start", x_start, 32'd0);
    check("rst_y_start", y_start, 32'd0);
    check("rst_theta_out", theta_out, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    reset_n = 1'b1;

    // Pin the reference model with hand-computed values.
    check("model_add_2_minus_pi", fadd(32'h40000000, NEG_PI), 32'hBF921FB6);
    check("model_add_m2_plus_pi", fadd(32'hC0000000, PI), 32'h3F921FB6);
    check("model_add_pi_minus_pi", fadd(PI, NEG_PI), 32'h00000000);
    check("model_add_1p5_1p5", fadd(32'h3FC00000, 32'h3FC00000), 32'h40400000);
    check("model_tie_even", fadd(32'h3F800000, 32'h33800000), 32'h3F800000);
    check("model_tie_odd", fadd(32'h3F800001, 32'h33800000), 32'h3F800002);
    model(32'h3F000000, e_theta, e_x, e_err, e_lat, e_data);
    check("model_half_theta", e_theta, 32'h3F000000);
    check("model_half_x", e_x, K_POS);
    check("model_half_lat", 32'(e_lat), 32'd3);
    model(32'hC0000000, e_theta, e_x, e_err, e_lat, e_data);
    check("model_m2_theta", e_theta, 32'h3F921FB6);
    check("model_m2_x", e_x, K_NEG);
    model(32'h40E00000, e_theta, e_x, e_err, e_lat, e_data);
    check("model_7_theta", e_theta, fadd(32'h40E00000, NEG_2PI));
    check("model_7_lat", 32'(e_lat), 32'd4);

    for (int i = 0; i < 12; i++) send(vecs[i], 0, 1'b0);

    // Back-pressure with a busy-time input pulse that must be ignored.
    send(32'h3F800000, 5, 1'b1);
    // Non-finite input.
    send(32'h7F800000, 0, 1'b0);
    // Leave a nonzero result in the output registers before the reset test.
    send(32'h40000000, 0, 1'b0);

    // Reset asserted while reducing 100.0: everything returns to reset values.
    @(negedge clk);
    in_valid = 1'b1;
    theta_in = 32'h42C80000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_x_start", x_start, 32'd0);
    check("mid_rst_theta_out", theta_out, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    send(32'h3F000000, 0, 1'b0);
    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_theta_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time bound expired");
    $fatal(1, "watchdog");
  end

endmodule
